// File: rtl/xbar_input_port_fifo.sv
// Crossbar ingress port: valid/ready flit intake into a first-word-fall-through FIFO,
// presenting the head flit with its destination and a one-hot request vector.
module xbar_input_port_fifo #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 4,
   parameter int NUM_DEST = 4,
   localparam int DEST_W  = $clog2(NUM_DEST),
   localparam int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_data,
   input  logic [DEST_W-1:0]   in_dest,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_data,
   output logic [DEST_W-1:0]   out_dest,
   output logic [NUM_DEST-1:0] out_req,
   output logic [CNT_W-1:0]    count,
   output logic [7:0]          bad_dest_cnt
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_data [DEPTH];
   logic [DEST_W-1:0] mem_dest [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              legal;
   logic              push;
   logic              wr;
   logic              pop;

   // Out-of-range destinations only exist when NUM_DEST leaves encodings unused.
   generate
      if ((1 << DEST_W) == NUM_DEST) begin : g_all_legal
         assign legal = 1'b1;
      end else begin : g_range_check
         assign legal = (in_dest < DEST_W'(NUM_DEST));
      end
   endgenerate

   assign in_ready  = (count != CNT_W'(DEPTH)) & ~flush;
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign wr        = push & legal;
   assign pop       = out_valid & out_ready & ~flush;

   // Gating keeps the head fields at zero when empty instead of exposing stale storage.
   assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
   assign out_dest  = out_valid ? mem_dest[rd_ptr] : '0;

   always_comb begin
      out_req = '0;
      for (int i = 0; i < NUM_DEST; i++) begin
         out_req[i] = out_valid & (out_dest == DEST_W'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (wr) begin
         mem_data[wr_ptr] <= in_data;
         mem_dest[wr_ptr] <= in_dest;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (wr && !pop) begin
            count <= count + 1'b1;
         end else if (!wr && pop) begin
            count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bad_dest_cnt <= '0;
      end else if (push && !legal && bad_dest_cnt != 8'hFF) begin
         bad_dest_cnt <= bad_dest_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_xbar_input_port_fifo.sv
// Directed bench for xbar_input_port_fifo: a per-cycle vector table plus short
// sequences for streaming, backpressure, illegal destinations, flush and async reset.
module tb_xbar_input_port_fifo;

   logic       clk = 1'b0;
   logic       reset;

   logic       flush, in_valid, in_ready, out_valid, out_ready;
   logic [7:0] in_data, out_data, bad_dest_cnt;
   logic [1:0] in_dest, out_dest;
   logic [3:0] out_req;
   logic [2:0] count;

   logic       flush3, in_valid3, in_ready3, out_valid3, out_ready3;
   logic [7:0] in_data3, out_data3, bad_dest_cnt3;
   logic [1:0] in_dest3, out_dest3;
   logic [2:0] out_req3;
   logic [2:0] count3;

   int total = 0;
   int nbad  = 0;

   always #5 clk = ~clk;

   xbar_input_port_fifo #(.DATA_W(8), .DEPTH(4), .NUM_DEST(4)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dest(in_dest),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_dest(out_dest),
      .out_req(out_req), .count(count), .bad_dest_cnt(bad_dest_cnt)
   );

   xbar_input_port_fifo #(.DATA_W(8), .DEPTH(4), .NUM_DEST(3)) dut3 (
      .clk(clk), .reset(reset), .flush(flush3),
      .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3), .in_dest(in_dest3),
      .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3), .out_dest(out_dest3),
      .out_req(out_req3), .count(count3), .bad_dest_cnt(bad_dest_cnt3)
   );

   typedef struct {
      logic       iv;
      logic [7:0] id;
      logic [1:0] idst;
      logic       ordy;
      logic       fl;
      logic [2:0] cnt;
      logic       ov;
      logic [7:0] dat;
      logic [1:0] dst;
      logic       ir;
      logic [3:0] req;
   } vec_t;

   vec_t vt [18];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //          iv  id     dst  ordy fl  cnt ov dat    dst  ir  req
      vt[0]  = '{1, 8'hA5, 2'd2, 0, 0, 3'd1, 1, 8'hA5, 2'd2, 1, 4'b0100};
      vt[1]  = '{0, 8'h00, 2'd0, 1, 0, 3'd0, 0, 8'h00, 2'd0, 1, 4'b0000};
      vt[2]  = '{1, 8'h01, 2'd0, 0, 0, 3'd1, 1, 8'h01, 2'd0, 1, 4'b0001};
      vt[3]  = '{1, 8'h02, 2'd1, 0, 0, 3'd2, 1, 8'h01, 2'd0, 1, 4'b0001};
      vt[4]  = '{1, 8'h03, 2'd2, 0, 0, 3'd3, 1, 8'h01, 2'd0, 1, 4'b0001};
      vt[5]  = '{1, 8'h04, 2'd3, 0, 0, 3'd4, 1, 8'h01, 2'd0, 0, 4'b0001};
      vt[6]  = '{1, 8'h05, 2'd0, 0, 0, 3'd4, 1, 8'h01, 2'd0, 0, 4'b0001};
      vt[7]  = '{1, 8'h05, 2'd0, 1, 0, 3'd3, 1, 8'h02, 2'd1, 1, 4'b0010};
      vt[8]  = '{1, 8'h05, 2'd0, 0, 0, 3'd4, 1, 8'h02, 2'd1, 0, 4'b0010};
      vt[9]  = '{0, 8'h00, 2'd0, 1, 0, 3'd3, 1, 8'h03, 2'd2, 1, 4'b0100};
      vt[10] = '{0, 8'h00, 2'd0, 1, 0, 3'd2, 1, 8'h04, 2'd3, 1, 4'b1000};
      vt[11] = '{0, 8'h00, 2'd0, 1, 0, 3'd1, 1, 8'h05, 2'd0, 1, 4'b0001};
      vt[12] = '{0, 8'h00, 2'd0, 1, 0, 3'd0, 0, 8'h00, 2'd0, 1, 4'b0000};
      vt[13] = '{1, 8'h11, 2'd0, 0, 0, 3'd1, 1, 8'h11, 2'd0, 1, 4'b0001};
      vt[14] = '{1, 8'h22, 2'd1, 0, 0, 3'd2, 1, 8'h11, 2'd0, 1, 4'b0001};
      vt[15] = '{1, 8'h33, 2'd2, 0, 0, 3'd3, 1, 8'h11, 2'd0, 1, 4'b0001};
      vt[16] = '{1, 8'h44, 2'd3, 1, 1, 3'd0, 0, 8'h00, 2'd0, 0, 4'b0000};
      vt[17] = '{0, 8'h00, 2'd0, 0, 0, 3'd0, 0, 8'h00, 2'd0, 1, 4'b0000};

      reset = 1'b1;
      flush = 0; in_valid = 0; in_data = 0; in_dest = 0; out_ready = 0;
      flush3 = 0; in_valid3 = 0; in_data3 = 0; in_dest3 = 0; out_ready3 = 0;
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      step();

      check("rst_count", 32'(count), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_req", 32'(out_req), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_out_dest", 32'(out_dest), 0);
      check("rst_bad_dest", 32'(bad_dest_cnt), 0);
      check("rst_bad_dest3", 32'(bad_dest_cnt3), 0);

      for (int i = 0; i < 18; i++) begin
         in_valid = vt[i].iv; in_data = vt[i].id; in_dest = vt[i].idst;
         out_ready = vt[i].ordy; flush = vt[i].fl;
         step();
         check($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].cnt));
         check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vt[i].ov));
         check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vt[i].dat));
         check($sformatf("vec%0d_out_dest", i), 32'(out_dest), 32'(vt[i].dst));
         check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vt[i].ir));
         check($sformatf("vec%0d_out_req", i), 32'(out_req), 32'(vt[i].req));
      end
      flush = 0; in_valid = 0; out_ready = 0;

      // Streaming at occupancy 2: values 0..19 in order, wrapping the pointers.
      in_dest = 2'd1;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1; in_data = 8'(k);
         step();
      end
      check("stream_prefill", 32'(count), 2);
      for (int k = 2; k < 20; k++) begin
         in_valid = 1; in_data = 8'(k); out_ready = 1;
         check($sformatf("stream_head%0d", k - 2), 32'(out_data), 32'(k - 2));
         step();
         check($sformatf("stream_count%0d", k), 32'(count), 2);
      end
      in_valid = 0;
      for (int k = 18; k < 20; k++) begin
         check($sformatf("stream_head%0d", k), 32'(out_data), 32'(k));
         step();
      end
      out_ready = 0;
      check("stream_drained", 32'(count), 0);

      // Head held under backpressure while new flits queue behind it.
      in_valid = 1; in_data = 8'h3C; in_dest = 2'd1;
      step();
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'($urandom_range(0, 1)); in_data = 8'($urandom); in_dest = 2'($urandom);
         step();
         check($sformatf("hold%0d_data", c), 32'(out_data), 32'h3C);
         check($sformatf("hold%0d_req", c), 32'(out_req), 32'b0010);
      end
      in_valid = 0; out_ready = 1;
      repeat (5) step();
      out_ready = 0;
      check("hold_drained", 32'(count), 0);

      // Illegal destination on the three-output instance.
      in_valid3 = 1; in_data3 = 8'h77; in_dest3 = 2'd3;
      step();
      in_data3 = 8'h12; in_dest3 = 2'd1;
      step();
      in_valid3 = 0;
      check("bad_cnt1", 32'(bad_dest_cnt3), 1);
      check("bad_count", 32'(count3), 1);
      check("bad_head_dest", 32'(out_dest3), 1);
      check("bad_head_data", 32'(out_data3), 32'h12);
      check("bad_head_req", 32'(out_req3), 32'b010);
      in_valid3 = 1; in_dest3 = 2'd3;
      for (int n = 0; n < 300; n++) step();
      in_valid3 = 0;
      check("bad_saturate", 32'(bad_dest_cnt3), 255);
      check("bad_count_kept", 32'(count3), 1);
      flush3 = 1;
      step();
      flush3 = 0;
      check("flush_keeps_bad", 32'(bad_dest_cnt3), 255);
      check("flush3_count", 32'(count3), 0);

      // Asynchronous reset mid-stream, observed before any further clock edge.
      in_valid = 1; in_data = 8'h5A; in_dest = 2'd0;
      step();
      step();
      in_valid = 0;
      check("pre_areset_count", 32'(count), 2);
      #3 reset = 1'b1;
      #1;
      check("areset_count", 32'(count), 0);
      check("areset_out_valid", 32'(out_valid), 0);
      check("areset_out_req", 32'(out_req), 0);

      $display("test done: total=%0d bad=%0d", total, nbad);
      $finish;
   end

endmodule

// File: doc/xbar_input_port_fifo.md
Name: xbar_input_port_fifo

Overview:
Parametrised crossbar ingress port: accepts flits over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
Presents the head flit to the crossbar with its destination and a one-hot request vector.
Replaces the single-register, no-backpressure input stage.
One instance per crossbar input; the crossbar arbiter drives out_ready.

Parameters:
DATA_W, 8, payload width in bits
DEPTH, 4, FIFO entries; power of two, >= 2
NUM_DEST, 4, crossbar output count, >= 2
DEST_W, $clog2(NUM_DEST), derived localparam, destination field width
CNT_W, $clog2(DEPTH+1), derived localparam, occupancy width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous FIFO clear
in_valid  input  1  upstream flit valid
in_ready  output  1  port can accept a flit
in_data  input  DATA_W  flit payload
in_dest  input  DEST_W  destination output index
out_valid  output  1  head flit valid
out_ready  input  1  crossbar accepts head flit this cycle
out_data  output  DATA_W  head flit payload
out_dest  output  DEST_W  head flit destination
out_req  output  NUM_DEST  one-hot of out_dest, gated by out_valid
count  output  CNT_W  current occupancy
bad_dest_cnt  output  8  saturating count of dropped illegal-destination flits

Behaviour:
- Reset (async, active-high):
  - Pointers and count go to 0.
  - out_valid=0, out_req=0, in_ready=1, bad_dest_cnt=0.
  - out_data and out_dest are 0.
  - Storage contents are don't-care.
- Push: in_valid & in_ready at a rising edge.
- Pop: out_valid & out_ready at a rising edge.
- in_ready = !(count==DEPTH) & !flush.
  - Registered-state derived only; no combinational path from out_ready.
  - Consequence: a push is never accepted while full, even if a pop occurs in the same cycle.
- FIFO is first-word-fall-through:
  - out_data and out_dest reflect the head entry whenever count>0.
  - A flit pushed into an empty FIFO at edge N is visible with out_valid=1 after edge N (1-cycle latency).
  - There is no same-cycle bypass.
- out_valid = (count != 0).
- out_req[i] = out_valid & (out_dest==i).
- out_data and out_dest hold stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop (count between 1 and DEPTH-1): count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Illegal destination (in_dest >= NUM_DEST; reachable only when NUM_DEST is not a power of two):
  - The handshake completes (in_ready honoured) but the flit is not written.
  - bad_dest_cnt increments by 1 and saturates at 255.
  - count is unaffected; a pop in the same cycle still proceeds.
- flush=1 at an edge:
  - Pointers and count go to 0; any pop that cycle is ignored.
  - in_ready=0 during the flush cycle, so no push occurs.
  - bad_dest_cnt is not cleared.
- Full (count==DEPTH): in_ready=0; pops proceed normally; in_ready returns to 1 the cycle after a pop.
- Empty: out_valid=0, out_req=0; out_ready is ignored.
- Reset asserted mid-transfer: all flits are discarded immediately and there is no partial state.

Test Plan:
- Reset, then push 0xA5 with dest 2 on an idle port. Required response:
  - one cycle later: out_valid=1, out_data=0xA5, out_dest=2, out_req=4'b0100, count=1.
  - after out_ready=1 for 1 cycle: out_valid=0.
- Push 0x01..0x04 with out_ready=0 (DEPTH=4). Required response:
  - count=4, in_ready=0; a 5th flit 0x05 held on in_valid is not accepted.
  - after one pop: 0x01 leaves, in_ready=1 next cycle, 0x05 is accepted, order 0x02,0x03,0x04,0x05 preserved.
- Continuous push and pop for 20 flits (values 0..19) at count=2. Required response:
  - count stays 2 throughout.
  - output sequence is exactly 0..19 with no gaps, exercising pointer wrap.
- Random backpressure on out_ready while holding out_ready=0 for 3 cycles with head=0x3C. Required response: out_data stays 0x3C and out_req is unchanged throughout.
- NUM_DEST=3: push a flit with dest 3, then a flit with dest 1. Required response:
  - bad_dest_cnt=1, count=1, head dest=1.
  - after 300 illegal pushes: bad_dest_cnt=255.
- Fill to 3 entries, assert flush for 1 cycle with in_valid=1 and out_ready=1. Required response:
  - next cycle: count=0, out_valid=0, nothing accepted or popped.
  - async reset mid-stream: count=0 and out_valid=0 with no clock edge.
